// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI register controller: register
// address map, frame length and control FSM state encoding.
package spi_reg_pkg;

  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

  localparam int unsigned NUM_REGS   = 5;
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CNT_W      = 5;

  localparam logic [CNT_W-1:0] CNT_FRAME    = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_HALF     = CNT_W'(FRAME_BITS / 2);
  localparam logic [CNT_W-1:0] CNT_RD_LATCH = CNT_W'(FRAME_BITS / 2 - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with single-cycle
// rise/fall pulses derived from the synchronized level.
module spi_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_register_controller.sv
// SPI-slave write path into the five PWM control registers.
// Optional readback of registers on cipo is enabled by defining SPI_READBACK_EN.
module spi_register_controller
  import spi_reg_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [6:0]  MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ncs_lvl, ncs_rise, ncs_fall;
  logic copi_lvl, copi_rise, copi_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .din(sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ncs_sync (
    .clk(clk), .rst_n(rst_n), .din(ncs),
    .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_copi_sync (
    .clk(clk), .rst_n(rst_n), .din(copi),
    .level(copi_lvl), .rise(copi_rise), .fall(copi_fall)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        shift_q, shift_d;
  logic [7:0]         regs_q [NUM_REGS];
  logic [7:0]         regs_d [NUM_REGS];
  logic               wr_strobe_q, wr_strobe_d;

`ifdef SPI_READBACK_EN
  logic               rd_act_q, rd_act_d;
  logic [7:0]         rd_shift_q, rd_shift_d;
  logic               cipo_q, cipo_d;
  logic [7:0]         rd_val;
  logic               unused_sig;
  assign unused_sig = ^{sclk_lvl, copi_rise, copi_fall};
`else
  logic               unused_sig;
  assign unused_sig = ^{sclk_lvl, sclk_fall, ncs_lvl, copi_rise, copi_fall};
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (ncs_fall) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shift_d = '0;
          // an sclk edge coincident with the select edge is the first bit
          if (sclk_rise) begin
            cnt_d   = 5'd1;
            shift_d = {15'b0, copi_lvl};
          end
        end
      end
      SHIFT: begin
        if (ncs_rise) begin
          state_d = (cnt_q == CNT_FRAME) ? COMMIT : IDLE;
        end else if (sclk_rise) begin
          shift_d = {shift_q[14:0], copi_lvl};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 5'd1;
        end
      end
      COMMIT: begin
        state_d = IDLE;
        if (shift_q[15] && (shift_q[14:8] <= MAX_ADDR)) begin
          wr_strobe_d = 1'b1;
          case (shift_q[14:8])
            ADDR_EN_OUT_7_0:  regs_d[0] = shift_q[7:0];
            ADDR_EN_OUT_15_8: regs_d[1] = shift_q[7:0];
            ADDR_EN_PWM_7_0:  regs_d[2] = shift_q[7:0];
            ADDR_EN_PWM_15_8: regs_d[3] = shift_q[7:0];
            ADDR_PWM_DUTY:    regs_d[4] = shift_q[7:0];
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef SPI_READBACK_EN
    rd_act_d   = rd_act_q;
    rd_shift_d = rd_shift_q;
    cipo_d     = cipo_q;

    case (shift_d[6:0])
      ADDR_EN_OUT_7_0:  rd_val = regs_q[0];
      ADDR_EN_OUT_15_8: rd_val = regs_q[1];
      ADDR_EN_PWM_7_0:  rd_val = regs_q[2];
      ADDR_EN_PWM_15_8: rd_val = regs_q[3];
      ADDR_PWM_DUTY:    rd_val = regs_q[4];
      default:          rd_val = '0;
    endcase
    if (shift_d[6:0] > MAX_ADDR) rd_val = '0;

    // latch on the 8th counted bit, using the just-shifted header byte
    if (state_q == SHIFT && !ncs_rise && sclk_rise && cnt_q == CNT_RD_LATCH && !shift_d[7]) begin
      rd_act_d   = 1'b1;
      rd_shift_d = rd_val;
    end
    if (sclk_fall && rd_act_q && cnt_q >= CNT_HALF && cnt_q < CNT_FRAME) begin
      cipo_d     = rd_shift_q[7];
      rd_shift_d = {rd_shift_q[6:0], 1'b0};
    end
    if (ncs_lvl || state_q != SHIFT) begin
      rd_act_d = 1'b0;
      cipo_d   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      regs_q      <= '{default: '0};
      wr_strobe_q <= 1'b0;
`ifdef SPI_READBACK_EN
      rd_act_q    <= 1'b0;
      rd_shift_q  <= '0;
      cipo_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
`ifdef SPI_READBACK_EN
      rd_act_q    <= rd_act_d;
      rd_shift_q  <= rd_shift_d;
      cipo_q      <= cipo_d;
`endif
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];
  assign wr_strobe       = wr_strobe_q;

`ifdef SPI_READBACK_EN
  assign cipo = cipo_q;
`else
  assign cipo = 1'b0;
`endif

endmodule

// File: doc/spi_register_controller.md
# spi_register_controller

SPI-slave configuration controller that owns the PWM peripheral's control registers. It receives 16-bit write frames from an external SPI master and commits them atomically into five 8-bit registers that drive the PWM block directly. Those registers are output enables for bits 7:0 and 15:8, PWM enables for bits 7:0 and 15:8, and the shared duty cycle. It sits between the top-level input pins and `pwm_peripheral`, in the single `clk` domain.

## Interface
Parameters:
- SYNC_STAGES, 2, flops in each pin synchronizer (min 2)
- MAX_ADDR, 7'h04, highest writable register address

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- sclk  in  1  SPI clock, asynchronous to clk, mode 0
- copi  in  1  SPI data in, asynchronous
- ncs  in  1  SPI chip select, active low, asynchronous
- cipo  out  1  SPI data out (readback only, else 0)
- en_reg_out_7_0  out  8  output enable, pins 7:0
- en_reg_out_15_8  out  8  output enable, pins 15:8
- en_reg_pwm_7_0  out  8  PWM-mode enable, pins 7:0
- en_reg_pwm_15_8  out  8  PWM-mode enable, pins 15:8
- pwm_duty_cycle  out  8  shared duty cycle, 0x00=0%, 0xFF=always high
- wr_strobe  out  1  one-cycle pulse on each successful commit

## Operation
- sclk, copi and ncs each pass through a SYNC_STAGES flop synchronizer.
  - sclk and ncs also get a one-flop edge detector.
- Frame format, MSB first: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
- ncs falling edge (synchronized): clear the bit counter and the shift register.
- Each synchronized sclk rising edge while ncs is low:
  - shift copi into bit 0 of a 16-bit shift register
  - increment the 5-bit bit counter, saturating at 17
- sclk edges while ncs is high are ignored.
- ncs rising edge (synchronized) commits only if all three hold:
  - bit counter == 16
  - bit15 == 1
  - address <= MAX_ADDR
- Address map for commits: 0x00 en_reg_out_7_0, 0x01 en_reg_out_15_8, 0x02 en_reg_pwm_7_0, 0x03 en_reg_pwm_15_8, 0x04 pwm_duty_cycle.
- On a commit, write the target register and pulse wr_strobe. Every other case discards the frame with no state change:
  - short frame (<16 bits)
  - long frame (>16 bits)
  - read frame
  - out-of-range address
- Control FSM states:
  - IDLE → SHIFT on ncs fall
  - SHIFT → COMMIT on ncs rise with count==16
  - SHIFT → IDLE on ncs rise otherwise
  - COMMIT → IDLE unconditionally (one cycle)
- Reset (any time, including mid-frame):
  - all five registers 0x00, wr_strobe 0, cipo 0
  - counter and shift register 0, FSM IDLE, synchronizer flops 0
  - a frame in progress when reset deasserts is discarded; the first edge accepted after reset is an ncs fall.

## Timing
- Register latency: a register changes on the clk edge SYNC_STAGES+2 edges after ncs rises at the pin.
- wr_strobe is high in that same cycle only.
- Simultaneous synchronized ncs rise and sclk rise: ncs wins and the sclk edge is not counted.
- Simultaneous synchronized ncs fall and sclk rise: counter clears and this sclk edge counts as bit 1.
- Back-to-back frames need ncs high for at least SYNC_STAGES+2 clk cycles.
- sclk high and low phases must each be at least SYNC_STAGES+1 clk periods. Faster sclk is unsupported; dropped bits then show up as a discarded frame.
- All outputs are registered; no combinational path from pins to outputs.

## Configuration
- SPI_READBACK_EN defined:
  - A read frame (bit15 = 0) latches the addressed register once the 8th bit is counted.
  - Data is shifted MSB first on cipo, updated on each synchronized sclk falling edge for bits 9..16.
  - Out-of-range address returns 0x00.
  - cipo is 0 whenever ncs is high; read frames never commit.
- SPI_READBACK_EN undefined: cipo tied 0, read frames silently discarded, readback logic absent.

## Structure
- Package spi_reg_pkg holds:
  - address localparams ADDR_EN_OUT_7_0 … ADDR_PWM_DUTY
  - FRAME_BITS = 16
  - FSM state typedef (IDLE, SHIFT, COMMIT)
- One sub-module, spi_sync_edge: SYNC_STAGES synchronizer plus rise/fall pulse outputs, instantiated for sclk, ncs and copi (copi uses only the level output).

## Test plan
- Reset values: assert rst_n mid-frame → all registers 0x00, wr_strobe 0, next complete frame commits normally.
- Write 0x80_F0 (addr 0x00, data 0xF0) → en_reg_out_7_0 = 0xF0 exactly SYNC_STAGES+2 clk after ncs rise, one wr_strobe pulse.
- Write each address 0x00–0x04 with 0xA5, 0x5A, 0x3C, 0xC3, 0x80 → each register holds its value and the others are unchanged.
- Address 0x05 with data 0xFF, then a 15-bit frame and a 17-bit frame → no register change, no wr_strobe.
- Read frame 0x04_00 without SPI_READBACK_EN → no change, cipo 0. With SPI_READBACK_EN after duty = 0x80 → cipo shifts 1,0,0,0,0,0,0,0.
- Two back-to-back writes with minimum ncs-high gap and minimum sclk phases → both commit in order.
